// File: rtl/pip_overlay_mixer.sv
// rtl/pip_overlay_mixer.sv - PIP window compositor: stream realignment, border, alpha fade, lost-stream fill
module pip_overlay_mixer #(
  parameter int          PIP_X_S     = 440,
  parameter int          PIP_Y_S     = 330,
  parameter int          DST_W       = 200,
  parameter int          DST_H       = 150,
  parameter int          PIP_LAT     = 2,
  parameter int          BORDER_W    = 2,
  parameter logic [23:0] BORDER_RGB  = 24'hFFFFFF,
  parameter logic [23:0] LOST_RGB    = 24'hFF00FF,
  parameter int          ALPHA_MAX   = 16,
  parameter int          LOST_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] vga_x,
  input  logic [9:0] vga_y,
  input  logic       video_on,
  input  logic       vga_hs,
  input  logic       vga_vs,
  input  logic [7:0] bg_r,
  input  logic [7:0] bg_g,
  input  logic [7:0] bg_b,
  input  logic       pip_de,
  input  logic [7:0] pip_r,
  input  logic [7:0] pip_g,
  input  logic [7:0] pip_b,
  input  logic       fade_en,
  input  logic       border_en,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_de,
  output logic       out_hs,
  output logic       out_vs,
  output logic [4:0] alpha,
  output logic       pip_lost
);

  // Tap layout: {x, y, video_on, hs, vs, r, g, b}; syncs idle high
  localparam int              TW       = 47;
  localparam logic [TW-1:0]   TAP_RST  = {20'd0, 1'b0, 1'b1, 1'b1, 24'd0};
  localparam logic [10:0]     WX0      = 11'(PIP_X_S);
  localparam logic [10:0]     WX1      = 11'(PIP_X_S + DST_W);
  localparam logic [10:0]     WY0      = 11'(PIP_Y_S);
  localparam logic [10:0]     WY1      = 11'(PIP_Y_S + DST_H);
  localparam logic [10:0]     BX0      = 11'(PIP_X_S - BORDER_W);
  localparam logic [10:0]     BX1      = 11'(PIP_X_S + DST_W + BORDER_W);
  localparam logic [10:0]     BY0      = 11'(PIP_Y_S - BORDER_W);
  localparam logic [10:0]     BY1      = 11'(PIP_Y_S + DST_H + BORDER_W);
  localparam logic [4:0]      AMAX     = 5'(ALPHA_MAX);
  localparam int              MW       = (LOST_FRAMES < 2) ? 1 : $clog2(LOST_FRAMES + 1);
  localparam logic [MW-1:0]   MISS_MAX = MW'(LOST_FRAMES);

  typedef enum logic [1:0] {HIDDEN, RISING, SHOWN, FALLING} fade_state_t;

  logic [TW-1:0] tap [PIP_LAT];
  logic [9:0]    a_x, a_y;
  logic          a_von, a_hs, a_vs;
  logic [7:0]    a_r, a_g, a_b;
  logic [10:0]   ax, ay;
  logic          a_win, a_grow, a_brd, hit;

  logic          b_win, b_brd, b_von, b_hs, b_vs, b_pde;
  logic [23:0]   b_bg;
  logic [11:0]   b_pp_r, b_pp_g, b_pp_b, b_bp_r, b_bp_g, b_bp_b;
  logic [4:0]    inv_alpha;

  logic          vs_prev, frame_ev, seen;
  logic [MW-1:0] miss_cnt;

  fade_state_t   state_q, state_d;
  logic [4:0]    alpha_d, alpha_up, alpha_dn;

  assign {a_x, a_y, a_von, a_hs, a_vs, a_r, a_g, a_b} = tap[PIP_LAT-1];

  assign ax        = {1'b0, a_x};
  assign ay        = {1'b0, a_y};
  assign a_win     = (ax >= WX0) && (ax < WX1) && (ay >= WY0) && (ay < WY1);
  assign a_grow    = (ax >= BX0) && (ax < BX1) && (ay >= BY0) && (ay < BY1);
  assign a_brd     = a_grow && !a_win;
  assign hit       = a_win && pip_de;
  assign inv_alpha = 5'd16 - alpha;
  assign frame_ev  = vs_prev && !a_vs;
  assign alpha_up  = (alpha >= AMAX) ? AMAX : alpha + 5'd1;
  assign alpha_dn  = (alpha == 5'd0) ? 5'd0 : alpha - 5'd1;

  // Stage A: delay raster and background so they line up with the late pip stream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIP_LAT; i++) tap[i] <= TAP_RST;
    end else begin
      tap[0] <= {vga_x, vga_y, video_on, vga_hs, vga_vs, bg_r, bg_g, bg_b};
      for (int i = 1; i < PIP_LAT; i++) tap[i] <= tap[i-1];
    end
  end

  // Stage B: register window/border classification and the blend products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_win  <= 1'b0;
      b_brd  <= 1'b0;
      b_von  <= 1'b0;
      b_hs   <= 1'b1;
      b_vs   <= 1'b1;
      b_pde  <= 1'b0;
      b_bg   <= 24'd0;
      b_pp_r <= 12'd0;
      b_pp_g <= 12'd0;
      b_pp_b <= 12'd0;
      b_bp_r <= 12'd0;
      b_bp_g <= 12'd0;
      b_bp_b <= 12'd0;
    end else begin
      b_win  <= a_win;
      b_brd  <= a_brd;
      b_von  <= a_von;
      b_hs   <= a_hs;
      b_vs   <= a_vs;
      b_pde  <= pip_de;
      b_bg   <= {a_r, a_g, a_b};
      b_pp_r <= {4'd0, pip_r} * {7'd0, alpha};
      b_pp_g <= {4'd0, pip_g} * {7'd0, alpha};
      b_pp_b <= {4'd0, pip_b} * {7'd0, alpha};
      b_bp_r <= {4'd0, a_r} * {7'd0, inv_alpha};
      b_bp_g <= {4'd0, a_g} * {7'd0, inv_alpha};
      b_bp_b <= {4'd0, a_b} * {7'd0, inv_alpha};
    end
  end

  // Stage C: prioritised output select; the sum of products never exceeds 255<<4
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {out_r, out_g, out_b} <= 24'd0;
      out_de <= 1'b0;
      out_hs <= 1'b1;
      out_vs <= 1'b1;
    end else begin
      out_de <= b_von;
      out_hs <= b_hs;
      out_vs <= b_vs;
      if (!b_von) begin
        {out_r, out_g, out_b} <= 24'd0;
      end else if (b_win && pip_lost) begin
        {out_r, out_g, out_b} <= LOST_RGB;
      end else if (b_win && b_pde) begin
        out_r <= 8'((13'(b_pp_r) + 13'(b_bp_r)) >> 4);
        out_g <= 8'((13'(b_pp_g) + 13'(b_bp_g)) >> 4);
        out_b <= 8'((13'(b_pp_b) + 13'(b_bp_b)) >> 4);
      end else if (b_win) begin
        {out_r, out_g, out_b} <= b_bg;
      end else if (b_brd && border_en && (alpha != 5'd0)) begin
        {out_r, out_g, out_b} <= BORDER_RGB;
      end else begin
        {out_r, out_g, out_b} <= b_bg;
      end
    end
  end

  // Watchdog: a frame with no window pixel counts as a miss; a hit on the event cycle belongs to the ending frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev  <= 1'b1;
      seen     <= 1'b0;
      miss_cnt <= '0;
      pip_lost <= 1'b0;
    end else begin
      vs_prev <= a_vs;
      if (frame_ev) begin
        seen <= 1'b0;
        if (seen || hit) begin
          miss_cnt <= '0;
          pip_lost <= 1'b0;
        end else begin
          if (miss_cnt != MISS_MAX) miss_cnt <= miss_cnt + 1'b1;
          if (miss_cnt >= MISS_MAX - 1'b1) pip_lost <= 1'b1;
        end
      end else if (hit) begin
        seen <= 1'b1;
      end
    end
  end

  // Fade state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HIDDEN;
      alpha   <= 5'd0;
    end else begin
      state_q <= state_d;
      alpha   <= alpha_d;
    end
  end

  // Fade next state: one alpha step per frame toward the requested visibility
  always_comb begin
    state_d = state_q;
    alpha_d = alpha;
    if (frame_ev) begin
      case (state_q)
        HIDDEN: begin
          if (fade_en) begin
            alpha_d = alpha_up;
            state_d = (alpha_up == AMAX) ? SHOWN : RISING;
          end
        end
        RISING, FALLING: begin
          if (fade_en) begin
            alpha_d = alpha_up;
            state_d = (alpha_up == AMAX) ? SHOWN : RISING;
          end else begin
            alpha_d = alpha_dn;
            state_d = (alpha_dn == 5'd0) ? HIDDEN : FALLING;
          end
        end
        SHOWN: begin
          if (!fade_en) begin
            alpha_d = alpha_dn;
            state_d = (alpha_dn == 5'd0) ? HIDDEN : FALLING;
          end
        end
        default: begin
          state_d = HIDDEN;
          alpha_d = 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pip_overlay_mixer.sv
// tb/tb_pip_overlay_mixer.sv - self-checking bench for pip_overlay_mixer
module tb_pip_overlay_mixer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] vga_x = '0, vga_y = '0;
  logic       video_on = 1'b0, vga_hs = 1'b1, vga_vs = 1'b1;
  logic [7:0] bg_r = '0, bg_g = '0, bg_b = '0;
  logic       pip_de = 1'b0;
  logic [7:0] pip_r = '0, pip_g = '0, pip_b = '0;
  logic       fade_en = 1'b0, border_en = 1'b1;
  logic [7:0] out_r, out_g, out_b;
  logic       out_de, out_hs, out_vs;
  logic [4:0] alpha;
  logic       pip_lost;

  always #20 clk = ~clk;

  pip_overlay_mixer dut (
    .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y), .video_on(video_on),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
    .pip_de(pip_de), .pip_r(pip_r), .pip_g(pip_g), .pip_b(pip_b),
    .fade_en(fade_en), .border_en(border_en),
    .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_de(out_de),
    .out_hs(out_hs), .out_vs(out_vs), .alpha(alpha), .pip_lost(pip_lost)
  );

  typedef struct {
    logic [23:0] pix;
    logic        de, hs, vs;
    int          lit;
  } exp_t;

  exp_t        exp_pix   [int];
  logic [4:0]  exp_alpha [int];
  logic        exp_lost  [int];

  int  cyc = 0;
  int  n_chk = 0, n_fail = 0;

  // model state: per-frame alpha and watchdog
  int          m_alpha = 0, m_miss = 0;
  bit          m_lost = 0, m_seen = 0;
  bit          prev_vs = 1;
  logic [24:0] ph0 = '0, ph1 = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endtask

  // compare process: pixel/timing 4 cycles after the coordinate, alpha/lost 3 cycles after
  always @(negedge clk) begin
    if (exp_pix.exists(cyc - 4)) begin
      exp_t e;
      e = exp_pix[cyc - 4];
      chk("out_rgb", {8'h0, out_r, out_g, out_b}, {8'h0, e.pix});
      chk("out_de", {31'd0, out_de}, {31'd0, e.de});
      chk("out_hs", {31'd0, out_hs}, {31'd0, e.hs});
      chk("out_vs", {31'd0, out_vs}, {31'd0, e.vs});
      if (e.lit >= 0) chk("lit_rgb", {8'h0, out_r, out_g, out_b}, e.lit);
      exp_pix.delete(cyc - 4);
    end
    if (exp_alpha.exists(cyc - 3)) begin
      chk("alpha", {27'd0, alpha}, {27'd0, exp_alpha[cyc - 3]});
      chk("pip_lost", {31'd0, pip_lost}, {31'd0, exp_lost[cyc - 3]});
      exp_alpha.delete(cyc - 3);
      exp_lost.delete(cyc - 3);
    end
  end

  task automatic drive(input int x, input int y, input bit von, input bit hs, input bit vs,
                       input logic [23:0] bgc, input bit pd, input logic [23:0] pipc, input int lit);
    exp_t e;
    bit win, brd, hit;
    int a;
    logic [23:0] px;
    win = (x >= 440) && (x < 640) && (y >= 330) && (y < 480);
    brd = !win && (x >= 438) && (x < 642) && (y >= 328) && (y < 482);
    hit = win && pd;
    if (prev_vs && !vs) begin
      if (m_seen || hit) begin
        m_miss = 0;
        m_lost = 0;
      end else begin
        if (m_miss < 2) m_miss++;
        m_lost = (m_miss >= 2);
      end
      m_seen = 0;
      if (fade_en) m_alpha = (m_alpha < 16) ? m_alpha + 1 : 16;
      else         m_alpha = (m_alpha > 0) ? m_alpha - 1 : 0;
    end else if (hit) begin
      m_seen = 1;
    end
    prev_vs = vs;
    a = m_alpha;
    if (!von)                              px = 24'h0;
    else if (win && m_lost)                px = 24'hFF00FF;
    else if (win && pd) begin
      for (int c = 0; c < 3; c++)
        px[c*8 +: 8] = 8'((int'(pipc[c*8 +: 8]) * a + int'(bgc[c*8 +: 8]) * (16 - a)) / 16);
    end
    else if (win)                          px = bgc;
    else if (brd && border_en && a != 0)   px = 24'hFFFFFF;
    else                                   px = bgc;
    e.pix = px; e.de = von; e.hs = hs; e.vs = vs; e.lit = lit;
    exp_pix[cyc]   = e;
    exp_alpha[cyc] = 5'(a);
    exp_lost[cyc]  = m_lost;
    vga_x = 10'(x); vga_y = 10'(y); video_on = von; vga_hs = hs; vga_vs = vs;
    {bg_r, bg_g, bg_b} = bgc;
    {pip_de, pip_r, pip_g, pip_b} = ph1;
    ph1 = ph0;
    ph0 = {pd, pipc};
    @(posedge clk); #1;
  endtask

  task automatic blank(input bit vs);
    drive(0, 0, 0, 1, vs, 24'h0, 0, 24'h0, -1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_pix.delete(); exp_alpha.delete(); exp_lost.delete();
    m_alpha = 0; m_miss = 0; m_lost = 0; m_seen = 0; prev_vs = 1;
    ph0 = '0; ph1 = '0;
    #1;
    chk("rst_rgb", {8'h0, out_r, out_g, out_b}, 0);
    chk("rst_de", {31'd0, out_de}, 0);
    chk("rst_hs", {31'd0, out_hs}, 1);
    chk("rst_vs", {31'd0, out_vs}, 1);
    chk("rst_alpha", {27'd0, alpha}, 0);
    chk("rst_lost", {31'd0, pip_lost}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode 0: no pip_de, 1: pip_de on every window pixel, 2: single pixel at (440,330)
  task automatic gen_frame(input bit fe, input bit be, input int mode,
                           input int lit440, input int lit439, input bit rst_mid);
    int rows [8];
    int cols [9];
    int x, y, lit;
    bit win, pd;
    rows = '{200, 328, 329, 330, 331, 479, 480, 481};
    cols = '{437, 438, 439, 440, 441, 639, 640, 641, 642};
    repeat (4) blank(1);
    fade_en = fe;
    border_en = be;
    repeat (3) blank(0);
    repeat (4) blank(1);
    for (int ri = 0; ri < 8; ri++) begin
      y = rows[ri];
      drive(0, y, 0, 0, 1, 24'h0, 0, 24'h0, -1);
      for (int ci = 0; ci < 9; ci++) begin
        x = cols[ci];
        win = (x >= 440) && (x < 640) && (y >= 330) && (y < 480);
        pd = (mode == 1) ? win : (mode == 2) ? (x == 440 && y == 330) : 1'b0;
        lit = (y == 330 && x == 440) ? lit440 : (y == 330 && x == 439) ? lit439 : -1;
        drive(x, y, 1, 1, 1, (y == 330) ? 24'h0 : {8'(x ^ y), 8'h80, 8'(y)},
              pd, {8'hFF, 8'(x + y), 8'h40}, lit);
        if (rst_mid && y == 200 && ci == 3) do_reset();
      end
    end
    drive(500, 400, 0, 1, 1, 24'h123456, mode == 1, 24'hFFFFFF, 0);
  endtask

  initial begin
    int lit;
    int fo_alpha [6];
    int fo_lit   [6];
    fo_alpha = '{4, 3, 2, 1, 0, 0};
    fo_lit   = '{'h3F0010, 'h2F000C, 'h1F0008, 'h0F0004, 0, 0};

    #5;
    do_reset();

    // fade in over 20 frames
    for (int k = 1; k <= 20; k++) begin
      if (k == 1)       lit = 'h0F0004;
      else if (k == 8)  lit = 'h7F0120;
      else if (k >= 16) lit = 'hFF0240;
      else              lit = -1;
      gen_frame(1, 1, 1, lit, 'hFFFFFF, 0);
      chk("fade_in_alpha", {27'd0, alpha}, (k < 16) ? k : 16);
    end

    // single-pixel alignment marker, border column at 439
    gen_frame(1, 1, 2, 'hFF0240, 'hFFFFFF, 0);

    // watchdog: two empty frames, then recovery
    gen_frame(1, 1, 0, 0, 'hFFFFFF, 0);
    chk("wd_lost_0", {31'd0, pip_lost}, 0);
    gen_frame(1, 1, 0, 0, 'hFFFFFF, 0);
    chk("wd_lost_1", {31'd0, pip_lost}, 0);
    gen_frame(1, 1, 2, 'hFF00FF, 'hFFFFFF, 0);
    chk("wd_lost_2", {31'd0, pip_lost}, 1);
    gen_frame(1, 1, 1, 'hFF0240, 'hFFFFFF, 0);
    chk("wd_lost_3", {31'd0, pip_lost}, 0);

    // border disabled
    gen_frame(1, 0, 1, 'hFF0240, 0, 0);

    // fade out mid-rise
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      gen_frame(1, 1, 1, (k == 1) ? 'h0F0004 : -1, 'hFFFFFF, 0);
      chk("rise_alpha", {27'd0, alpha}, k);
    end
    for (int j = 0; j < 6; j++) begin
      gen_frame(0, 1, 1, fo_lit[j], (fo_alpha[j] != 0) ? 'hFFFFFF : 0, 0);
      chk("fall_alpha", {27'd0, alpha}, fo_alpha[j]);
    end
    gen_frame(1, 1, 1, 'h0F0004, 'hFFFFFF, 0);
    chk("rerise_alpha", {27'd0, alpha}, 1);

    // reset in the middle of a frame
    gen_frame(1, 1, 1, -1, 'hFFFFFF, 0);
    gen_frame(1, 1, 1, 0, 0, 1);
    chk("post_rst_alpha", {27'd0, alpha}, 0);
    gen_frame(0, 1, 1, 0, 0, 0);
    chk("post_rst_hidden", {27'd0, alpha}, 0);
    gen_frame(1, 1, 1, 'h0F0004, 'hFFFFFF, 0);
    chk("post_rst_rise", {27'd0, alpha}, 1);

    repeat (6) blank(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
